// File: rtl/conv2d_event_engine.sv
// Event-driven KxK convolution: per spiking input channel, sweeps the kernel footprint and
// read-modify-writes packed membrane potentials, one position per cycle with a 1-cycle write stage.
module conv2d_event_engine #(
  parameter int COORD_BITS             = 8,
  parameter int IN_CHANNELS            = 4,
  parameter int OUT_CHANNELS           = 4,
  parameter int IMG_WIDTH              = 32,
  parameter int IMG_HEIGHT             = 32,
  parameter int BITS_PER_NEURON        = 8,
  parameter int BITS_PER_KERNEL_WEIGHT = 4,
  parameter int KERNEL_SIZE            = 3,
  parameter int SATURATE               = 1,
  localparam int KW_AW = (IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE > 1) ?
                         $clog2(IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE) : 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        event_valid,
  output logic                                        event_ready,
  input  logic [COORD_BITS-1:0]                       event_x,
  input  logic [COORD_BITS-1:0]                       event_y,
  input  logic [IN_CHANNELS-1:0]                      event_spikes,
  output logic                                        fm_rd_en,
  output logic [COORD_BITS-1:0]                       fm_rd_x,
  output logic [COORD_BITS-1:0]                       fm_rd_y,
  input  logic [OUT_CHANNELS*BITS_PER_NEURON-1:0]     fm_rd_data,
  output logic                                        fm_wr_en,
  output logic [COORD_BITS-1:0]                       fm_wr_x,
  output logic [COORD_BITS-1:0]                       fm_wr_y,
  output logic [OUT_CHANNELS*BITS_PER_NEURON-1:0]     fm_wr_data,
  output logic                                        kw_en,
  output logic [KW_AW-1:0]                            kw_addr,
  input  logic [OUT_CHANNELS*BITS_PER_KERNEL_WEIGHT-1:0] kw_data,
  output logic                                        busy,
  output logic                                        done
);

  localparam int K   = KERNEL_SIZE;
  localparam int KK  = K * K;
  localparam int BPN = BITS_PER_NEURON;
  localparam int BKW = BITS_PER_KERNEL_WEIGHT;
  localparam int SW  = COORD_BITS + 2;
  localparam int CW  = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int KCW = (K > 1) ? $clog2(K) : 1;

  localparam logic [KCW-1:0]       KMAX   = KCW'(K - 1);
  localparam logic signed [SW-1:0] HALF_S = SW'(K / 2);
  localparam logic signed [SW-1:0] W_LIM  = SW'(IMG_WIDTH);
  localparam logic signed [SW-1:0] H_LIM  = SW'(IMG_HEIGHT);
  localparam logic [BPN-1:0]       NMAX   = {1'b0, {(BPN-1){1'b1}}};
  localparam logic [BPN-1:0]       NMIN   = {1'b1, {(BPN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [COORD_BITS-1:0]   x_q, x_d, y_q, y_d;
  logic [IN_CHANNELS-1:0]  mask_q, mask_d;
  logic [KCW-1:0]          kx_q, kx_d, ky_q, ky_d;
  logic                    wr_vld_q, wr_vld_d;
  logic [COORD_BITS-1:0]   wr_x_q, wr_x_d, wr_y_q, wr_y_d;
  logic                    done_q, done_d;

  logic [CW-1:0]           chan;
  logic [IN_CHANNELS-1:0]  mask_clr;
  logic signed [SW-1:0]    tx, ty;
  logic                    in_bounds, hazard, issue, advance;
  logic [KW_AW-1:0]        kw_addr_calc;

  always_comb begin
    chan = '0;
    for (int i = IN_CHANNELS - 1; i >= 0; i--) begin
      if (mask_q[i]) chan = CW'(i);
    end
  end

  assign mask_clr = mask_q & ~(IN_CHANNELS'(1) << chan);

  // Extra two bits keep negative offsets and off-image events distinguishable from in-range coords.
  assign tx = signed'({2'b00, x_q}) + signed'(SW'(kx_q)) - HALF_S;
  assign ty = signed'({2'b00, y_q}) + signed'(SW'(ky_q)) - HALF_S;

  assign in_bounds = !tx[SW-1] && (tx < W_LIM) && !ty[SW-1] && (ty < H_LIM);
  assign hazard    = in_bounds && wr_vld_q &&
                     (wr_x_q == tx[COORD_BITS-1:0]) && (wr_y_q == ty[COORD_BITS-1:0]);
  assign issue     = (state_q == SWEEP) && in_bounds && !hazard;
  assign advance   = (state_q == SWEEP) && !hazard;

  assign kw_addr_calc = KW_AW'(int'(chan) * KK + int'(ky_q) * K + int'(kx_q));

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    mask_d   = mask_q;
    kx_d     = kx_q;
    ky_d     = ky_q;
    done_d   = 1'b0;
    wr_vld_d = issue;
    wr_x_d   = issue ? tx[COORD_BITS-1:0] : wr_x_q;
    wr_y_d   = issue ? ty[COORD_BITS-1:0] : wr_y_q;
    case (state_q)
      IDLE: begin
        if (event_valid) begin
          x_d    = event_x;
          y_d    = event_y;
          mask_d = event_spikes;
          kx_d   = '0;
          ky_d   = '0;
          if (event_spikes == '0) done_d  = 1'b1;
          else                    state_d = SWEEP;
        end
      end
      SWEEP: begin
        if (advance) begin
          if (kx_q == KMAX) begin
            kx_d = '0;
            if (ky_q == KMAX) begin
              ky_d   = '0;
              mask_d = mask_clr;
              if (mask_clr == '0) begin
                state_d = DRAIN;
                done_d  = 1'b1;
              end
            end else begin
              ky_d = ky_q + KCW'(1);
            end
          end else begin
            kx_d = kx_q + KCW'(1);
          end
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      mask_q   <= '0;
      kx_q     <= '0;
      ky_q     <= '0;
      wr_vld_q <= 1'b0;
      wr_x_q   <= '0;
      wr_y_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      mask_q   <= mask_d;
      kx_q     <= kx_d;
      ky_q     <= ky_d;
      wr_vld_q <= wr_vld_d;
      wr_x_q   <= wr_x_d;
      wr_y_q   <= wr_y_d;
      done_q   <= done_d;
    end
  end

  assign event_ready = !rst && (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

  assign fm_rd_en = issue;
  assign kw_en    = issue;
  assign fm_rd_x  = issue ? tx[COORD_BITS-1:0] : '0;
  assign fm_rd_y  = issue ? ty[COORD_BITS-1:0] : '0;
  assign kw_addr  = issue ? kw_addr_calc : '0;

  assign fm_wr_en = wr_vld_q;
  assign fm_wr_x  = wr_vld_q ? wr_x_q : '0;
  assign fm_wr_y  = wr_vld_q ? wr_y_q : '0;

  for (genvar o = 0; o < OUT_CHANNELS; o++) begin : g_lane
    logic [BPN-1:0] rd;
    logic [BKW-1:0] w;
    logic [BPN-1:0] lane;
    assign rd = fm_rd_data[o*BPN +: BPN];
    assign w  = kw_data[o*BKW +: BKW];
    if (SATURATE != 0) begin : g_sat
      logic [BPN:0] s;
      assign s    = {rd[BPN-1], rd} + {{(BPN+1-BKW){w[BKW-1]}}, w};
      assign lane = (s[BPN] != s[BPN-1]) ? (s[BPN] ? NMIN : NMAX) : s[BPN-1:0];
    end else begin : g_wrap
      assign lane = rd + {{(BPN-BKW){w[BKW-1]}}, w};
    end
    assign fm_wr_data[o*BPN +: BPN] = wr_vld_q ? lane : '0;
  end

endmodule

// File: tb/tb_conv2d_event_engine.sv
// Directed bench for conv2d_event_engine: two instances (K=3 saturating, K=1 wrapping)
// attached to behavioural feature-map and kernel memories with one-cycle read latency.
module tb_conv2d_event_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   total = 0;
  int   bad   = 0;

  // Instance A: 8x8, K=3, IN=2, OUT=2, BPN=8, BKW=5, SATURATE=1
  logic a_ev_vld, a_ev_rdy;
  logic [7:0] a_ev_x, a_ev_y;
  logic [1:0] a_ev_spk;
  logic a_rd_en, a_wr_en, a_kw_en, a_busy, a_done;
  logic [7:0] a_rd_x, a_rd_y, a_wr_x, a_wr_y;
  logic [15:0] a_rd_dat, a_wr_dat;
  logic [4:0] a_kw_addr;
  logic [9:0] a_kw_dat;

  // Instance B: 8x8, K=1, IN=2, OUT=2, BPN=8, BKW=4, SATURATE=0
  logic b_ev_vld, b_ev_rdy;
  logic [7:0] b_ev_x, b_ev_y;
  logic [1:0] b_ev_spk;
  logic b_rd_en, b_wr_en, b_kw_en, b_busy, b_done;
  logic [7:0] b_rd_x, b_rd_y, b_wr_x, b_wr_y;
  logic [15:0] b_rd_dat, b_wr_dat;
  logic [0:0] b_kw_addr;
  logic [7:0] b_kw_dat;

  conv2d_event_engine #(.COORD_BITS(8), .IN_CHANNELS(2), .OUT_CHANNELS(2), .IMG_WIDTH(8),
    .IMG_HEIGHT(8), .BITS_PER_NEURON(8), .BITS_PER_KERNEL_WEIGHT(5), .KERNEL_SIZE(3),
    .SATURATE(1)) u_a (
    .clk(clk), .rst(rst), .event_valid(a_ev_vld), .event_ready(a_ev_rdy),
    .event_x(a_ev_x), .event_y(a_ev_y), .event_spikes(a_ev_spk),
    .fm_rd_en(a_rd_en), .fm_rd_x(a_rd_x), .fm_rd_y(a_rd_y), .fm_rd_data(a_rd_dat),
    .fm_wr_en(a_wr_en), .fm_wr_x(a_wr_x), .fm_wr_y(a_wr_y), .fm_wr_data(a_wr_dat),
    .kw_en(a_kw_en), .kw_addr(a_kw_addr), .kw_data(a_kw_dat), .busy(a_busy), .done(a_done));

  conv2d_event_engine #(.COORD_BITS(8), .IN_CHANNELS(2), .OUT_CHANNELS(2), .IMG_WIDTH(8),
    .IMG_HEIGHT(8), .BITS_PER_NEURON(8), .BITS_PER_KERNEL_WEIGHT(4), .KERNEL_SIZE(1),
    .SATURATE(0)) u_b (
    .clk(clk), .rst(rst), .event_valid(b_ev_vld), .event_ready(b_ev_rdy),
    .event_x(b_ev_x), .event_y(b_ev_y), .event_spikes(b_ev_spk),
    .fm_rd_en(b_rd_en), .fm_rd_x(b_rd_x), .fm_rd_y(b_rd_y), .fm_rd_data(b_rd_dat),
    .fm_wr_en(b_wr_en), .fm_wr_x(b_wr_x), .fm_wr_y(b_wr_y), .fm_wr_data(b_wr_dat),
    .kw_en(b_kw_en), .kw_addr(b_kw_addr), .kw_data(b_kw_dat), .busy(b_busy), .done(b_done));

  logic [15:0] fm_a [0:63];
  logic [15:0] fm_b [0:63];
  logic [9:0]  kw_a [0:31];
  logic [7:0]  kw_b [0:1];
  logic        clr, pre_we, pre_sel;
  logic [5:0]  pre_idx;
  logic [15:0] pre_val;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 64; i++) begin
        fm_a[i] <= '0;
        fm_b[i] <= '0;
      end
    end
    if (pre_we && !pre_sel) fm_a[pre_idx] <= pre_val;
    if (pre_we &&  pre_sel) fm_b[pre_idx] <= pre_val;
    if (a_rd_en) a_rd_dat <= fm_a[{a_rd_y[2:0], a_rd_x[2:0]}];
    if (a_wr_en) fm_a[{a_wr_y[2:0], a_wr_x[2:0]}] <= a_wr_dat;
    if (a_kw_en) a_kw_dat <= kw_a[a_kw_addr];
    if (b_rd_en) b_rd_dat <= fm_b[{b_rd_y[2:0], b_rd_x[2:0]}];
    if (b_wr_en) fm_b[{b_wr_y[2:0], b_wr_x[2:0]}] <= b_wr_dat;
    if (b_kw_en) b_kw_dat <= kw_b[b_kw_addr];
  end

  logic        lg_rd [0:24], lg_kw [0:24], lg_wr [0:24];
  logic        lg_done [0:24], lg_busy [0:24], lg_rdy [0:24];
  logic [4:0]  lg_addr [0:24];
  logic [7:0]  lg_wx [0:24], lg_wy [0:24];
  logic [15:0] lg_wd [0:24];

  task automatic clear_fm();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic preload(input logic sel, input logic [5:0] idx, input logic [15:0] v);
    @(negedge clk); pre_sel = sel; pre_idx = idx; pre_val = v; pre_we = 1'b1;
    @(negedge clk); pre_we = 1'b0;
  endtask

  // Offers one event to instance A in cycle 0 and logs cycles 1..ncyc at the falling edge.
  task automatic run_a(input logic [7:0] x, input logic [7:0] y, input logic [1:0] spk,
                       input int ncyc);
    @(negedge clk);
    a_ev_x = x; a_ev_y = y; a_ev_spk = spk; a_ev_vld = 1'b1;
    lg_rdy[0] = a_ev_rdy;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      a_ev_vld = 1'b0;
      lg_rd[c] = a_rd_en; lg_kw[c] = a_kw_en; lg_addr[c] = a_kw_addr;
      lg_wr[c] = a_wr_en; lg_wx[c] = a_wr_x; lg_wy[c] = a_wr_y; lg_wd[c] = a_wr_dat;
      lg_done[c] = a_done; lg_busy[c] = a_busy; lg_rdy[c] = a_ev_rdy;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (a_ev_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy_a got=%b want=0", a_ev_rdy); end
    total++; if (b_ev_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy_b got=%b want=0", b_ev_rdy); end
    total++; if ({a_busy, a_done, b_busy, b_done} !== 4'b0) begin bad++; $display("FAIL reset_busy_done got=%b want=0000", {a_busy, a_done, b_busy, b_done}); end
    total++; if ({a_rd_en, a_wr_en, a_kw_en, b_rd_en, b_wr_en, b_kw_en} !== 6'b0) begin bad++; $display("FAIL reset_strobes got=%b want=000000", {a_rd_en, a_wr_en, a_kw_en, b_rd_en, b_wr_en, b_kw_en}); end
    total++; if ({a_rd_x, a_rd_y, a_wr_x, a_wr_y, a_kw_addr, a_wr_dat} !== 53'b0) begin bad++; $display("FAIL reset_outputs got=%h want=0", {a_rd_x, a_rd_y, a_wr_x, a_wr_y, a_kw_addr, a_wr_dat}); end
    rst = 1'b0;
    @(negedge clk);
    total++; if ({a_ev_rdy, b_ev_rdy} !== 2'b11) begin bad++; $display("FAIL reset_release_rdy got=%b want=11", {a_ev_rdy, b_ev_rdy}); end
  endtask

  task automatic test_centre();
    clear_fm();
    run_a(8'd4, 8'd4, 2'b01, 12);
    total++; if (lg_rdy[0] !== 1'b1) begin bad++; $display("FAIL centre_accept_rdy got=%b want=1", lg_rdy[0]); end
    for (int c = 1; c <= 12; c++) begin
      logic exp_rd, exp_wr;
      int k;
      exp_rd = (c <= 9);
      total++; if (lg_rd[c] !== exp_rd || lg_kw[c] !== exp_rd) begin bad++; $display("FAIL centre_issue c=%0d got rd=%b kw=%b want=%b", c, lg_rd[c], lg_kw[c], exp_rd); end
      if (exp_rd) begin
        total++; if (lg_addr[c] !== 5'(c - 1)) begin bad++; $display("FAIL centre_addr c=%0d got=%0d want=%0d", c, lg_addr[c], c - 1); end
      end
      exp_wr = (c >= 2) && (c <= 10);
      total++; if (lg_wr[c] !== exp_wr) begin bad++; $display("FAIL centre_wr_en c=%0d got=%b want=%b", c, lg_wr[c], exp_wr); end
      if (exp_wr) begin
        k = c - 2;
        total++; if (lg_wx[c] !== 8'(3 + k % 3) || lg_wy[c] !== 8'(3 + k / 3)) begin bad++; $display("FAIL centre_wr_xy c=%0d got=(%0d,%0d) want=(%0d,%0d)", c, lg_wx[c], lg_wy[c], 3 + k % 3, 3 + k / 3); end
        total++; if (lg_wd[c] !== {8'(k + 1), 8'(k + 1)}) begin bad++; $display("FAIL centre_wr_dat c=%0d got=%h want=%h", c, lg_wd[c], {8'(k + 1), 8'(k + 1)}); end
      end
      total++; if (lg_done[c] !== (c == 10)) begin bad++; $display("FAIL centre_done c=%0d got=%b want=%b", c, lg_done[c], (c == 10)); end
      total++; if (lg_busy[c] !== (c <= 10)) begin bad++; $display("FAIL centre_busy c=%0d got=%b want=%b", c, lg_busy[c], (c <= 10)); end
    end
    total++; if (lg_rdy[11] !== 1'b1 || lg_rdy[10] !== 1'b0) begin bad++; $display("FAIL centre_rdy_return got c10=%b c11=%b want 0 1", lg_rdy[10], lg_rdy[11]); end
  endtask

  task automatic test_corner();
    int nwr;
    clear_fm();
    run_a(8'd0, 8'd0, 2'b11, 21);
    nwr = 0;
    for (int c = 1; c <= 21; c++) begin
      int p, k;
      logic exp_rd, exp_wr;
      logic [15:0] exp_wd;
      p = c - 1; k = p % 9;
      exp_rd = (c <= 18) && (k % 3 >= 1) && (k / 3 >= 1);
      total++; if (lg_rd[c] !== exp_rd || lg_kw[c] !== exp_rd) begin bad++; $display("FAIL corner_issue c=%0d got rd=%b kw=%b want=%b", c, lg_rd[c], lg_kw[c], exp_rd); end
      if (exp_rd) begin
        total++; if (lg_addr[c] !== 5'(p)) begin bad++; $display("FAIL corner_addr c=%0d got=%0d want=%0d", c, lg_addr[c], p); end
      end
      p = c - 2; k = (p < 0) ? 0 : p % 9;
      exp_wr = (c >= 2) && (c <= 19) && (k % 3 >= 1) && (k / 3 >= 1);
      total++; if (lg_wr[c] !== exp_wr) begin bad++; $display("FAIL corner_wr_en c=%0d got=%b want=%b", c, lg_wr[c], exp_wr); end
      if (exp_wr) begin
        nwr++;
        exp_wd = (p < 9) ? {8'(k + 1), 8'(k + 1)} : {8'(2 * k + 1), 8'(k)};
        total++; if (lg_wx[c] !== 8'(k % 3 - 1) || lg_wy[c] !== 8'(k / 3 - 1)) begin bad++; $display("FAIL corner_wr_xy c=%0d got=(%0d,%0d) want=(%0d,%0d)", c, lg_wx[c], lg_wy[c], k % 3 - 1, k / 3 - 1); end
        total++; if (lg_wd[c] !== exp_wd) begin bad++; $display("FAIL corner_wr_dat c=%0d got=%h want=%h", c, lg_wd[c], exp_wd); end
      end
      total++; if (lg_done[c] !== (c == 19)) begin bad++; $display("FAIL corner_done c=%0d got=%b want=%b", c, lg_done[c], (c == 19)); end
    end
    total++; if (nwr != 8) begin bad++; $display("FAIL corner_write_count got=%0d want=8", nwr); end
  endtask

  task automatic test_saturate();
    clear_fm();
    preload(1'b0, {3'd2, 3'd2}, {8'h80, 8'h7E});
    kw_a[13] = {5'(-3), 5'(5)};
    run_a(8'd2, 8'd2, 2'b10, 11);
    total++; if (lg_addr[1] !== 5'd9) begin bad++; $display("FAIL sat_first_addr got=%0d want=9", lg_addr[1]); end
    total++; if (lg_wd[2] !== 16'h00FF) begin bad++; $display("FAIL sat_plain_dat got=%h want=00ff", lg_wd[2]); end
    total++; if (lg_wr[6] !== 1'b1 || lg_wx[6] !== 8'd2 || lg_wy[6] !== 8'd2) begin bad++; $display("FAIL sat_wr_xy got en=%b (%0d,%0d) want 1 (2,2)", lg_wr[6], lg_wx[6], lg_wy[6]); end
    total++; if (lg_wd[6] !== 16'h807F) begin bad++; $display("FAIL sat_clamp_dat got=%h want=807f", lg_wd[6]); end
    kw_a[13] = {5'(4), 5'(-1)};
  endtask

  task automatic test_zero_spikes();
    run_a(8'd3, 8'd3, 2'b00, 3);
    total++; if (lg_done[1] !== 1'b1 || lg_done[2] !== 1'b0) begin bad++; $display("FAIL zero_done got c1=%b c2=%b want 1 0", lg_done[1], lg_done[2]); end
    total++; if (lg_busy[1] !== 1'b0 || lg_rdy[1] !== 1'b1) begin bad++; $display("FAIL zero_idle got busy=%b rdy=%b want 0 1", lg_busy[1], lg_rdy[1]); end
    for (int c = 1; c <= 3; c++) begin
      total++; if ({lg_rd[c], lg_kw[c], lg_wr[c]} !== 3'b0) begin bad++; $display("FAIL zero_strobes c=%0d got=%b want=000", c, {lg_rd[c], lg_kw[c], lg_wr[c]}); end
    end
  endtask

  task automatic test_wrap();
    clear_fm();
    kw_b[0] = {4'hD, 4'h5};
    preload(1'b1, {3'd1, 3'd1}, {8'h80, 8'h7E});
    @(negedge clk);
    b_ev_x = 8'd1; b_ev_y = 8'd1; b_ev_spk = 2'b01; b_ev_vld = 1'b1;
    @(negedge clk);
    b_ev_vld = 1'b0;
    total++; if (b_rd_en !== 1'b1 || b_rd_x !== 8'd1 || b_kw_addr !== 1'b0) begin bad++; $display("FAIL wrap_issue got rd=%b x=%0d addr=%0d want 1 1 0", b_rd_en, b_rd_x, b_kw_addr); end
    @(negedge clk);
    total++; if (b_wr_en !== 1'b1 || b_wr_dat !== 16'h7D83) begin bad++; $display("FAIL wrap_dat got en=%b dat=%h want 1 7d83", b_wr_en, b_wr_dat); end
    total++; if (b_done !== 1'b1) begin bad++; $display("FAIL wrap_done got=%b want=1", b_done); end
  endtask

  task automatic test_back_to_back();
    clear_fm();
    kw_b[0] = {4'hE, 4'h3};
    kw_b[1] = {4'h5, 4'h4};
    preload(1'b1, {3'd3, 3'd2}, {8'd20, 8'd10});
    @(negedge clk);
    b_ev_x = 8'd2; b_ev_y = 8'd3; b_ev_spk = 2'b11; b_ev_vld = 1'b1;
    @(negedge clk);
    b_ev_vld = 1'b0;
    total++; if (b_rd_en !== 1'b1 || b_kw_addr !== 1'b0) begin bad++; $display("FAIL hazard_c1 got rd=%b addr=%0d want 1 0", b_rd_en, b_kw_addr); end
    @(negedge clk);
    total++; if (b_rd_en !== 1'b0 || b_kw_en !== 1'b0) begin bad++; $display("FAIL hazard_stall got rd=%b kw=%b want 0 0", b_rd_en, b_kw_en); end
    total++; if (b_wr_en !== 1'b1 || b_wr_dat !== 16'h120D || b_done !== 1'b0) begin bad++; $display("FAIL hazard_c2_wr got en=%b dat=%h done=%b want 1 120d 0", b_wr_en, b_wr_dat, b_done); end
    @(negedge clk);
    total++; if (b_rd_en !== 1'b1 || b_kw_addr !== 1'b1 || b_wr_en !== 1'b0) begin bad++; $display("FAIL hazard_c3 got rd=%b addr=%0d wr=%b want 1 1 0", b_rd_en, b_kw_addr, b_wr_en); end
    @(negedge clk);
    total++; if (b_wr_en !== 1'b1 || b_wr_dat !== 16'h1711 || b_done !== 1'b1) begin bad++; $display("FAIL hazard_c4_wr got en=%b dat=%h done=%b want 1 1711 1", b_wr_en, b_wr_dat, b_done); end
    @(negedge clk);
    total++; if (b_ev_rdy !== 1'b1 || b_busy !== 1'b0) begin bad++; $display("FAIL hazard_c5_idle got rdy=%b busy=%b want 1 0", b_ev_rdy, b_busy); end
    total++; if (fm_b[{3'd3, 3'd2}] !== 16'h1711) begin bad++; $display("FAIL hazard_final_mem got=%h want=1711", fm_b[{3'd3, 3'd2}]); end
  endtask

  task automatic test_reset_mid();
    clear_fm();
    @(negedge clk);
    a_ev_x = 8'd4; a_ev_y = 8'd4; a_ev_spk = 2'b11; a_ev_vld = 1'b1;
    repeat (5) begin
      @(negedge clk);
      a_ev_vld = 1'b0;
    end
    total++; if (a_busy !== 1'b1 || a_rd_en !== 1'b1) begin bad++; $display("FAIL rstmid_active got busy=%b rd=%b want 1 1", a_busy, a_rd_en); end
    rst = 1'b1;
    @(negedge clk);
    total++; if ({a_rd_en, a_kw_en, a_wr_en, a_busy, a_done} !== 5'b0) begin bad++; $display("FAIL rstmid_quiet got=%b want=00000", {a_rd_en, a_kw_en, a_wr_en, a_busy, a_done}); end
    total++; if (a_ev_rdy !== 1'b0 || a_rd_x !== 8'd0 || a_kw_addr !== 5'd0) begin bad++; $display("FAIL rstmid_outs got rdy=%b x=%0d addr=%0d want 0 0 0", a_ev_rdy, a_rd_x, a_kw_addr); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (a_ev_rdy !== 1'b1 || a_busy !== 1'b0) begin bad++; $display("FAIL rstmid_release got rdy=%b busy=%b want 1 0", a_ev_rdy, a_busy); end
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0; pre_we = 1'b0; pre_sel = 1'b0; pre_idx = '0; pre_val = '0;
    a_ev_vld = 1'b0; a_ev_x = '0; a_ev_y = '0; a_ev_spk = '0;
    b_ev_vld = 1'b0; b_ev_x = '0; b_ev_y = '0; b_ev_spk = '0;
    for (int i = 0; i < 32; i++) kw_a[i] = '0;
    for (int k = 0; k < 9; k++) begin
      kw_a[k]     = {5'(k + 1), 5'(k + 1)};
      kw_a[9 + k] = {5'(k), 5'(-1)};
    end
    kw_b[0] = '0;
    kw_b[1] = '0;
    test_reset();
    test_centre();
    test_corner();
    test_saturate();
    test_zero_spikes();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv2d_event_engine.md
# conv2d_event_engine

Event-driven 2D convolution engine for the spiking convolution path. It accepts one input event at a time: a coordinate plus a spike bit per input channel. For every spiking input channel it sweeps the K×K kernel footprint around the event and performs a read-modify-write of the packed membrane potentials of all output channels at each in-bounds neighbour. It sits between the event capture stage and the feature-map memory arbiter, and owns the kernel weight BRAM read port.

## Interface
Parameters:
- COORD_BITS, 8: width of x/y coordinates.
- IN_CHANNELS, 4: input channels (spike bits per event).
- OUT_CHANNELS, 4: output channels packed per feature-map word.
- IMG_WIDTH, 32: feature map width.
- IMG_HEIGHT, 32: feature map height.
- BITS_PER_NEURON, 8: signed membrane potential width.
- BITS_PER_KERNEL_WEIGHT, 4: signed weight width.
- KERNEL_SIZE, 3: odd kernel side K, K ≥ 1.
- SATURATE, 1: 1 = clamp sums to neuron range, 0 = two's-complement wrap.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- event_valid  in  1  event offered.
- event_ready  out  1  engine can accept an event.
- event_x, event_y  in  COORD_BITS  event coordinate.
- event_spikes  in  IN_CHANNELS  bit c set = input channel c spiked.
- fm_rd_en  out  1  feature-map read strobe; data is returned 1 cycle later.
- fm_rd_x, fm_rd_y  out  COORD_BITS  read coordinate.
- fm_rd_data  in  OUT_CHANNELS*BITS_PER_NEURON  read data; channel o is in bits [o*BPN +: BPN].
- fm_wr_en  out  1  feature-map write strobe.
- fm_wr_x, fm_wr_y  out  COORD_BITS  write coordinate.
- fm_wr_data  out  OUT_CHANNELS*BITS_PER_NEURON  write data, same packing as fm_rd_data.
- kw_en  out  1  kernel BRAM read strobe; data is returned 1 cycle later.
- kw_addr  out  $clog2(IN_CHANNELS*K*K)  kernel address, computed as c*K*K + ky*K + kx.
- kw_data  in  OUT_CHANNELS*BITS_PER_KERNEL_WEIGHT  weights for all output channels, same lane packing.
- busy  out  1  high whenever the engine is not in IDLE.
- done  out  1  one-cycle pulse when an event is fully processed.

## Operation
- States are IDLE, SWEEP and DRAIN.
- IDLE:
  - event_ready=1.
  - On event_valid&&event_ready, latch the coordinate and spikes.
  - If spikes==0: pulse done the next cycle and stay in IDLE.
  - Otherwise go to SWEEP.
- SWEEP, issue stage:
  - The current channel c is the lowest set bit of the latched spike mask that is still pending.
  - Counters ky, kx run in raster order, 0..K-1 each.
  - Target is tx=x+kx-K/2, ty=y+ky-K/2. Compute it in signed COORD_BITS+2 arithmetic.
  - If 0≤tx<IMG_WIDTH and 0≤ty<IMG_HEIGHT: assert fm_rd_en (tx,ty) and kw_en (c*K*K+ky*K+kx) together.
  - Otherwise the cycle issues nothing.
  - Every position takes exactly one cycle, so each channel takes K*K cycles plus any stalls.
  - After (K-1,K-1): clear bit c. If no bits remain, go to DRAIN; otherwise start the next channel at (0,0) on the next cycle.
- Write stage (one cycle after each issue):
  - For each output lane o: fm_wr_data[o] = fm_rd_data[o] + sign-extended kw_data[o].
  - Write to the issued coordinate.
  - With SATURATE=1, clamp to [-2^(BPN-1), 2^(BPN-1)-1]. With SATURATE=0, wrap.
- Hazard:
  - If the issue coordinate equals the coordinate being written in the same cycle, stall the issue stage for one cycle (hold the counters, no strobes).
  - The stall guarantees read-after-write ordering.
  - This can only occur for K=1 with multiple channels, but the check is always present.
- DRAIN:
  - Completes the final write, pulses done, and returns to IDLE.
  - The cycle before DRAIN may be an issue-less out-of-bounds cycle; DRAIN is then a cycle with no write.
- Event coordinates outside the image are not rejected. Only in-bounds targets are updated.

## Timing
- Reset values:
  - event_ready=0 while rst is high, and 1 in the first cycle after rst is released.
  - All strobes 0, busy=0, done=0.
  - All coordinate, address and data outputs 0.
  - Pipeline valid cleared.
- Accept at cycle 0. Issue cycles are 1..N*K*K+S, where N is the popcount of spikes and S is the number of stalls.
  - DRAIN is cycle N*K*K+S+1, with done high in that cycle.
  - event_ready returns high in the next cycle.
- Throughput is one read-modify-write per cycle. There is no back-pressure from memory; the arbiter grants unconditionally.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values and the event dropped. Writes already committed remain.
- rst has priority over simultaneous event_valid.

## Test plan
- Centre hit (8×8, K=3, OUT=2, zero FM; w[0][k]=k+1 in both lanes). Event (4,4), spikes=01 → 9 writes (3,3)=1 … (5,5)=9, done in cycle 10.
- Corner clip. Event (0,0), spikes=11 → 4 writes per channel, only kernel indices 4,5,7,8; done in cycle 19; no strobes on out-of-bounds cycles.
- Saturation (BPN=8).
  - SATURATE=1: 126+5 → 127; −128+(−3) → −128.
  - SATURATE=0: 126+5 → −125.
- Zero spikes → no fm/kw strobes; done one cycle after accept.
- K=1, spikes=11, same coordinate → one stall cycle; final value is w0+w1; done in cycle 4.
- Assert rst during cycle 5 of a sweep → the next cycle has all strobes 0 and busy=0; event_ready is high after release.
